modadd_3x2_final: RTL

MODADD_3X2_FINAL -- requirements
Module: modadd_3x2_final

---
 rtl/modadd_3x2_final.sv | 84 ++++++++
 1 files changed

// File: rtl/modadd_3x2_final.sv
// Final modular-add stage: two-slot valid/ready pipeline that folds a stage-1 partial sum into [0, mod_m).
// Define MODADD_FINAL_ERRCNT_EN to build the saturating range-error counter; otherwise err_count is tied to 0.
module modadd_3x2_final #(
    parameter int DATA_WIDTH   = 18,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   lut_sum,
    input  logic [DATA_WIDTH-3:0]   trunc_sum,
    input  logic [DATA_WIDTH-3:0]   mod_m,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-3:0]   res,
    output logic                    range_err,
    output logic [ERRCNT_WIDTH-1:0] err_count
);
    localparam int RW = DATA_WIDTH - 2;
    localparam int SW = DATA_WIDTH + 1;

    logic          a_valid;
    logic [SW-1:0] a_sum;
    logic          b_advance;
    logic [SW:0]   d1;
    logic [SW:0]   d2;
    logic          s_lt_m;
    logic          s_ge_2m;
    logic          unused_diff_bits;

    // The output register is stage B, so it frees up whenever it is empty or being drained.
    assign b_advance = !out_valid || out_ready;
    assign in_ready  = !a_valid || b_advance;

    // One guard bit above the sum turns the MSB of each difference into its borrow flag.
    assign d1      = {1'b0, a_sum} - {4'b0, mod_m};
    assign d2      = {1'b0, a_sum} - {3'b0, mod_m, 1'b0};
    assign s_lt_m  = d1[SW];
    assign s_ge_2m = !d2[SW];
    assign unused_diff_bits = ^{d1[SW-1:RW], d2[SW-1:0]};

    // Stage A: capture the unreduced sum at full width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_sum   <= '0;
        end else if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_sum <= {3'b0, trunc_sum} + {1'b0, lut_sum};
            end
        end
    end

    // Stage B: pick the reduced residue and flag sums that a single subtraction cannot fold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            range_err <= 1'b0;
        end else if (b_advance) begin
            out_valid <= a_valid;
            if (a_valid) begin
                res       <= s_lt_m ? a_sum[RW-1:0] : d1[RW-1:0];
                range_err <= s_ge_2m || (mod_m == '0);
            end
        end
    end

`ifdef MODADD_FINAL_ERRCNT_EN
    // Counts flagged results only when they are actually handed downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && range_err && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
